// File: rtl/z80_ld_ixiy_ind_nn_seq.sv
// rtl/z80_ld_ixiy_ind_nn_seq.sv - LD IX/IY,(nn) multi-cycle sequencer
// Fetches nn, reads the word at nn over a byte bus and retires it to IX or IY.
module z80_ld_ixiy_ind_nn_seq #(
   parameter int WAIT_TIMEOUT = 0,
   parameter int TO_W         = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        iy_sel,
   input  logic [15:0] pc_in,
   input  logic        abort,
   output logic        bus_req,
   output logic [15:0] bus_addr,
   input  logic        bus_ack,
   input  logic [7:0]  bus_rdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        reg_wr_en,
   output logic        reg_wr_iy,
   output logic [15:0] reg_wr_data,
   output logic [15:0] pc_out,
   output logic [15:0] fi_raddr,
   output logic [15:0] fi_raddr2,
   output logic [7:0]  fi_rdata,
   output logic [7:0]  fi_rdata2
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_LO,
      S_FETCH_HI,
      S_READ_LO,
      S_READ_HI,
      S_WRITEBACK
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       pc_q;
   logic              iy_q;
   logic [15:0]       nn_q;
   logic [7:0]        lo_q;
   logic [7:0]        hi_q;
   logic [TO_W-1:0]   cnt_q;

   // Retired values are held here so the trace and result stay stable in IDLE.
   logic [15:0]       h_data_q;
   logic              h_iy_q;
   logic [15:0]       h_pc_q;
   logic [15:0]       h_raddr_q;
   logic [15:0]       h_raddr2_q;
   logic [7:0]        h_rdata_q;
   logic [7:0]        h_rdata2_q;

   logic              in_read;
   logic              timeout;

   always_comb begin
      state_d  = state_q;
      in_read  = 1'b0;
      bus_addr = 16'h0000;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH_LO;
         end
         S_FETCH_LO: begin
            in_read  = 1'b1;
            bus_addr = pc_q + 16'd2;
            if (bus_ack) state_d = S_FETCH_HI;
         end
         S_FETCH_HI: begin
            in_read  = 1'b1;
            bus_addr = pc_q + 16'd3;
            if (bus_ack) state_d = S_READ_LO;
         end
         S_READ_LO: begin
            in_read  = 1'b1;
            bus_addr = nn_q;
            if (bus_ack) state_d = S_READ_HI;
         end
         S_READ_HI: begin
            in_read  = 1'b1;
            bus_addr = nn_q + 16'd1;
            if (bus_ack) state_d = S_WRITEBACK;
         end
         S_WRITEBACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Timeout fires on the first ack-less cycle after WAIT_TIMEOUT wait cycles.
      timeout = in_read && !bus_ack && (WAIT_TIMEOUT != 0)
                && (cnt_q == TO_W'(WAIT_TIMEOUT));
      if (timeout) state_d = S_IDLE;
      if (abort && state_q != S_IDLE) state_d = S_IDLE;

      bus_req   = in_read;
      busy      = (state_q != S_IDLE);
      err       = timeout && !abort;
      done      = (state_q == S_WRITEBACK) && !abort;
      reg_wr_en = done;

      reg_wr_data = done ? {hi_q, lo_q}   : h_data_q;
      reg_wr_iy   = done ? iy_q           : h_iy_q;
      pc_out      = done ? pc_q + 16'd4   : h_pc_q;
      fi_raddr    = done ? nn_q           : h_raddr_q;
      fi_raddr2   = done ? nn_q + 16'd1   : h_raddr2_q;
      fi_rdata    = done ? lo_q           : h_rdata_q;
      fi_rdata2   = done ? hi_q           : h_rdata2_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         pc_q       <= 16'h0000;
         iy_q       <= 1'b0;
         nn_q       <= 16'h0000;
         lo_q       <= 8'h00;
         hi_q       <= 8'h00;
         cnt_q      <= '0;
         h_data_q   <= 16'h0000;
         h_iy_q     <= 1'b0;
         h_pc_q     <= 16'h0000;
         h_raddr_q  <= 16'h0000;
         h_raddr2_q <= 16'h0000;
         h_rdata_q  <= 8'h00;
         h_rdata2_q <= 8'h00;
      end else begin
         state_q <= state_d;

         if (state_q == S_IDLE && start) begin
            pc_q <= pc_in;
            iy_q <= iy_sel;
         end

         if (in_read && !bus_ack) cnt_q <= cnt_q + TO_W'(1);
         else                     cnt_q <= '0;

         if (in_read && bus_ack && !abort) begin
            case (state_q)
               S_FETCH_LO: nn_q[7:0]  <= bus_rdata;
               S_FETCH_HI: nn_q[15:8] <= bus_rdata;
               S_READ_LO:  lo_q       <= bus_rdata;
               S_READ_HI:  hi_q       <= bus_rdata;
               default:    ;
            endcase
         end

         if (done) begin
            h_data_q   <= {hi_q, lo_q};
            h_iy_q     <= iy_q;
            h_pc_q     <= pc_q + 16'd4;
            h_raddr_q  <= nn_q;
            h_raddr2_q <= nn_q + 16'd1;
            h_rdata_q  <= lo_q;
            h_rdata2_q <= hi_q;
         end
      end
   end

endmodule
